// File: rtl/rpn_key_cmd.sv
// Debounced four-key front end for the rpncalc stage: synchronise, qualify
// each press once, and deliver commands one per cycle lowest key first.
module rpn_key_cmd #(
    parameter int DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic [1:0]  mode,
    input  logic [15:0] val,
    output logic        cmd_valid,
    output logic [1:0]  cmd_key,
    output logic [1:0]  cmd_mode,
    output logic [15:0] cmd_val,
    output logic [7:0]  press_count
);

    localparam int CW = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } kstate_t;

    logic [3:0]    s1;
    logic [3:0]    s2;
    kstate_t       st     [4];
    kstate_t       st_n   [4];
    logic [CW-1:0] cnt    [4];
    logic [CW-1:0] cnt_n  [4];
    logic [3:0]    pending;
    logic [3:0]    pending_n;
    logic [3:0]    set;
    logic [3:0]    grant;
    logic [1:0]    idx;
    logic          emit;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 4'b1111;
            s2 <= 4'b1111;
            for (int k = 0; k < 4; k++) begin
                st[k]  <= RELEASED;
                cnt[k] <= '0;
            end
            pending     <= '0;
            cmd_valid   <= 1'b0;
            cmd_key     <= '0;
            cmd_mode    <= '0;
            cmd_val     <= '0;
            press_count <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            for (int k = 0; k < 4; k++) begin
                st[k]  <= st_n[k];
                cnt[k] <= cnt_n[k];
            end
            pending   <= pending_n;
            cmd_valid <= emit;
            if (emit) begin
                cmd_key     <= idx;
                cmd_mode    <= mode;
                cmd_val     <= val;
                press_count <= press_count + 8'd1;
            end
        end
    end

    // Per-key debounce FSMs; s2 is active-low.
    always_comb begin
        set = '0;
        for (int k = 0; k < 4; k++) begin
            st_n[k]  = st[k];
            cnt_n[k] = cnt[k];
            unique case (st[k])
                RELEASED: begin
                    if (!s2[k]) begin
                        st_n[k]  = PRESS_WAIT;
                        cnt_n[k] = ONE;
                    end else begin
                        cnt_n[k] = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s2[k]) begin
                        st_n[k]  = RELEASED;
                        cnt_n[k] = '0;
                    end else if (cnt[k] == LAST) begin
                        st_n[k] = PRESSED;
                        set[k]  = 1'b1;
                    end else begin
                        cnt_n[k] = cnt[k] + ONE;
                    end
                end
                PRESSED: begin
                    if (s2[k]) begin
                        st_n[k]  = RELEASE_WAIT;
                        cnt_n[k] = ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (!s2[k]) begin
                        st_n[k]  = PRESSED;
                        cnt_n[k] = '0;
                    end else if (cnt[k] == LAST) begin
                        st_n[k] = RELEASED;
                    end else begin
                        cnt_n[k] = cnt[k] + ONE;
                    end
                end
                default: begin
                    st_n[k]  = RELEASED;
                    cnt_n[k] = '0;
                end
            endcase
        end
    end

    // Lowest-index pending key wins; new sets are merged after the clear
    // so a press qualifying during another key's emission is kept.
    always_comb begin
        grant = '0;
        idx   = '0;
        if (pending[0]) begin
            grant = 4'b0001;
            idx   = 2'd0;
        end else if (pending[1]) begin
            grant = 4'b0010;
            idx   = 2'd1;
        end else if (pending[2]) begin
            grant = 4'b0100;
            idx   = 2'd2;
        end else if (pending[3]) begin
            grant = 4'b1000;
            idx   = 2'd3;
        end
        emit      = |pending;
        pending_n = (pending & ~grant) | set;
    end

endmodule

// File: tb/tb_rpn_key_cmd.sv
// Directed bench for rpn_key_cmd with DEBOUNCE=4.
module tb_rpn_key_cmd;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [1:0]  mode;
    logic [15:0] val;
    logic        cmd_valid;
    logic [1:0]  cmd_key;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_val;
    logic [7:0]  press_count;

    int checks = 0;
    int failures = 0;
    int n_emit = 0;
    int base;
    logic [1:0] last_key = 2'd0;

    rpn_key_cmd #(.DEBOUNCE(4)) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .mode(mode),
        .val(val),
        .cmd_valid(cmd_valid),
        .cmd_key(cmd_key),
        .cmd_mode(cmd_mode),
        .cmd_val(cmd_val),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) begin
            n_emit   = n_emit + 1;
            last_key = cmd_key;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key = 4'b1111;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        rst  = 1'b1;
        key  = 4'b1111;
        mode = 2'd0;
        val  = 16'h0;
        tick(3);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_key", 32'(cmd_key), 0);
        chk("rst_mode", 32'(cmd_mode), 0);
        chk("rst_val", 32'(cmd_val), 0);
        chk("rst_count", 32'(press_count), 0);
        rst = 1'b0;
        tick(2);

        // Clean press: E0 is the next edge; strobe after E6
        key  = 4'b1110;
        mode = 2'd2;
        val  = 16'h00A5;
        tick(6);
        chk("clean_early", 32'(cmd_valid), 0);
        tick(1);
        chk("clean_valid", 32'(cmd_valid), 1);
        chk("clean_key", 32'(cmd_key), 0);
        chk("clean_mode", 32'(cmd_mode), 2);
        chk("clean_val", 32'(cmd_val), 32'h00A5);
        chk("clean_count", 32'(press_count), 1);
        mode = 2'd1;
        val  = 16'h1234;
        tick(1);
        chk("clean_strobe", 32'(cmd_valid), 0);
        chk("hold_mode", 32'(cmd_mode), 2);
        chk("hold_val", 32'(cmd_val), 32'h00A5);
        tick(20);
        chk("clean_once", n_emit, 1);
        key = 4'b1111;
        tick(12);

        // Bounce never qualifies
        base = n_emit;
        for (int i = 0; i < 5; i++) begin
            key = 4'b1101;
            tick(2);
            key = 4'b1111;
            tick(2);
        end
        tick(12);
        chk("bounce_emit", n_emit - base, 0);
        chk("bounce_count", 32'(press_count), 1);

        // Long hold with release bounce
        base = n_emit;
        key  = 4'b1011;
        tick(100);
        for (int i = 0; i < 3; i++) begin
            key = 4'b1111;
            tick(1);
            key = 4'b1011;
            tick(1);
        end
        key = 4'b1111;
        tick(20);
        chk("hold_emit", n_emit - base, 1);
        chk("hold_key", 32'(last_key), 2);
        chk("hold_count", 32'(press_count), 2);

        // Simultaneous: keys 0..3 on consecutive cycles
        key = 4'b0000;
        tick(7);
        for (int k = 0; k < 4; k++) begin
            chk("sim_valid", 32'(cmd_valid), 1);
            chk("sim_key", 32'(cmd_key), k);
            tick(1);
        end
        chk("sim_end", 32'(cmd_valid), 0);
        chk("sim_count", 32'(press_count), 6);
        key = 4'b1111;
        tick(12);

        // Wrap from reset
        do_reset();
        chk("wrap_start", 32'(press_count), 0);
        base = n_emit;
        for (int i = 0; i < 256; i++) begin
            key = 4'b0111;
            tick(8);
            key = 4'b1111;
            tick(8);
            if (i == 254)
                chk("wrap_255", 32'(press_count), 255);
        end
        chk("wrap_emit", n_emit - base, 256);
        chk("wrap_count", 32'(press_count), 0);
        chk("wrap_key", 32'(cmd_key), 3);

        // Reset mid-debounce at E3
        base = n_emit;
        key  = 4'b1110;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", 32'(cmd_valid), 0);
        chk("mid_rst_key", 32'(cmd_key), 0);
        chk("mid_rst_count", 32'(press_count), 0);
        chk("mid_rst_val", 32'(cmd_val), 0);
        rst = 1'b0;
        tick(6);
        chk("mid_early", 32'(cmd_valid), 0);
        chk("mid_none", n_emit - base, 0);
        tick(1);
        chk("mid_valid", 32'(cmd_valid), 1);
        chk("mid_key", 32'(cmd_key), 0);
        tick(30);
        chk("mid_once", n_emit - base, 1);
        chk("mid_count", 32'(press_count), 1);
        key = 4'b1111;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
